// File: rtl/dc_sync_pkg.sv
// Shared types and constants for the Dreamcast raw-sync timing monitor.
package dc_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } SyncState;

  localparam int NTSC_LINE_CLKS = 3432;
  localparam int PAL_LINE_CLKS  = 3456;
  localparam int VGA_LINE_CLKS  = 1716;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Line counter must hold the longest nominal line without saturating.
  localparam int LINE_CNT_W  = $clog2(max3(NTSC_LINE_CLKS, PAL_LINE_CLKS, VGA_LINE_CLKS) + 1);
  localparam int FIELD_CNT_W = 10;

  typedef struct packed {
    logic [LINE_CNT_W-1:0]  line_length;
    logic [FIELD_CNT_W-1:0] field_lines;
    logic                   interlaced;
    logic                   is_pal;
  } TimingInfo;

  function automatic logic [LINE_CNT_W-1:0] absdiff_line(input logic [LINE_CNT_W-1:0] a,
                                                         input logic [LINE_CNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [FIELD_CNT_W-1:0] absdiff_field(input logic [FIELD_CNT_W-1:0] a,
                                                           input logic [FIELD_CNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer and registered falling-edge pulse for an active-low sync pin.
// SYNC_MONITOR_GLITCH_FILTER_EN inserts a 3-sample majority filter (+2 cycles latency).
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sync_n,
  output logic fall
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;
  logic       fall_q;

  // Idle level of the sync pins is high; resetting to 1 avoids a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sync_n};
      level_q <= level;
      fall_q  <= level_q & ~level;
    end
  end

`ifdef SYNC_MONITOR_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level = maj_q;
`else
  assign level = sync_q[1];
`endif

  assign fall = fall_q;

endmodule

// File: rtl/dc_sync_monitor.sv
// Dreamcast sync timing monitor: measures line/field timing, classifies the mode, declares lock.
// Build option SYNC_MONITOR_GLITCH_FILTER_EN enables the majority filter in sync_edge_detect.
//
// state  | meaning
// SEARCH | counting consecutive consistent fields toward lock
// LOCKED | timing outputs frozen, watching for deviation
// LOST   | no hsync edge within the timeout window
module dc_sync_monitor
  import dc_sync_pkg::*;
#(
  parameter int STABLE_FIELDS = 4,
  parameter int LINE_TOL      = 2,
  parameter int TIMEOUT_CLKS  = 270000,
  parameter int VGA_THRESHOLD = 2500,
  parameter int PAL_THRESHOLD = 290
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   _hsync,
  input  logic                   _vsync,
  output logic                   stable,
  output logic                   no_signal,
  output logic                   resync,
  output logic [LINE_CNT_W-1:0]  line_length,
  output logic [FIELD_CNT_W-1:0] field_lines,
  output logic                   interlaced,
  output logic                   vga_mode,
  output logic                   is_pal,
  output logic [23:0]            timing_info
);

  localparam logic [LINE_CNT_W-1:0]  HCNT_MAX = '1;
  localparam logic [FIELD_CNT_W-1:0] VCNT_MAX = '1;
  localparam logic [LINE_CNT_W-1:0]  TOL      = LINE_CNT_W'(LINE_TOL);
  localparam logic [LINE_CNT_W-1:0]  VGA_TH   = LINE_CNT_W'(VGA_THRESHOLD);
  localparam logic [FIELD_CNT_W-1:0] PAL_TH   = FIELD_CNT_W'(PAL_THRESHOLD);
  localparam int                     TO_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0]        TO_LOAD  = TO_W'(TIMEOUT_CLKS - 1);
  localparam int                     CNT_W    = $clog2(STABLE_FIELDS + 1);
  localparam logic [CNT_W-1:0]       LOCK_CNT = CNT_W'(STABLE_FIELDS);

  logic hs_fall;
  logic vs_fall;

  sync_edge_detect u_hs_edge (
    .clock  (clock),
    .reset  (reset),
    .sync_n (_hsync),
    .fall   (hs_fall)
  );

  sync_edge_detect u_vs_edge (
    .clock  (clock),
    .reset  (reset),
    .sync_n (_vsync),
    .fall   (vs_fall)
  );

  logic [LINE_CNT_W-1:0]  hcnt_q;
  logic [LINE_CNT_W-1:0]  meas_len_q;
  logic [LINE_CNT_W-1:0]  prev_len_q;
  logic [FIELD_CNT_W-1:0] vcnt_q;
  logic [FIELD_CNT_W-1:0] prev_lines_q;
  logic                   seeded_q;
  logic                   sat_q;
  logic [TO_W-1:0]        to_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt_q       <= '0;
      meas_len_q   <= '0;
      prev_len_q   <= '0;
      vcnt_q       <= '0;
      prev_lines_q <= '0;
      seeded_q     <= 1'b0;
      sat_q        <= 1'b0;
      to_q         <= TO_LOAD;
    end else begin
      if (hs_fall) begin
        hcnt_q     <= '0;
        meas_len_q <= (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + 1'b1;
        to_q       <= TO_LOAD;
      end else begin
        if (hcnt_q != HCNT_MAX) hcnt_q <= hcnt_q + 1'b1;
        if (to_q != '0)         to_q   <= to_q - 1'b1;
      end

      // An hsync coincident with vsync belongs to the new field.
      if (vs_fall) begin
        vcnt_q       <= hs_fall ? FIELD_CNT_W'(1) : '0;
        prev_len_q   <= meas_len_q;
        prev_lines_q <= vcnt_q;
        seeded_q     <= 1'b1;
        sat_q        <= 1'b0;
      end else begin
        if (hs_fall && vcnt_q != VCNT_MAX) vcnt_q <= vcnt_q + 1'b1;
        if (hcnt_q == HCNT_MAX || vcnt_q == VCNT_MAX) sat_q <= 1'b1;
      end
    end
  end

  logic                   field_bad;
  logic                   consistent;
  logic                   len_dev;
  logic                   timeout;
  logic                   meas_is_vga;
  logic [FIELD_CNT_W-1:0] min_lines;

  assign field_bad   = sat_q | (hcnt_q == HCNT_MAX) | (vcnt_q == VCNT_MAX);
  assign consistent  = seeded_q && !field_bad
                       && (absdiff_line(meas_len_q, prev_len_q) <= TOL)
                       && (absdiff_field(vcnt_q, prev_lines_q) <= FIELD_CNT_W'(1));
  assign timeout     = (to_q == '0) && !hs_fall;
  assign meas_is_vga = meas_len_q < VGA_TH;
  assign min_lines   = (vcnt_q < prev_lines_q) ? vcnt_q : prev_lines_q;

  SyncState               state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   stable_q, stable_d;
  logic                   no_signal_q, no_signal_d;
  logic                   resync_q, resync_d;
  logic [LINE_CNT_W-1:0]  line_length_q, line_length_d;
  logic [FIELD_CNT_W-1:0] field_lines_q, field_lines_d;
  logic                   interlaced_q, interlaced_d;
  logic                   vga_q, vga_d;
  logic                   pal_q, pal_d;

  assign cnt_inc = cnt_q + 1'b1;
  assign len_dev = absdiff_line(meas_len_q, line_length_q) > TOL;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stable_d      = stable_q;
    no_signal_d   = no_signal_q & ~hs_fall;
    resync_d      = 1'b0;
    line_length_d = line_length_q;
    field_lines_d = field_lines_q;
    interlaced_d  = interlaced_q;
    vga_d         = vga_q;
    pal_d         = pal_q;

    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          if (!consistent) begin
            cnt_d = '0;
          end else if (cnt_inc == LOCK_CNT) begin
            state_d       = LOCKED;
            cnt_d         = '0;
            stable_d      = 1'b1;
            line_length_d = meas_len_q;
            field_lines_d = min_lines;
            interlaced_d  = vcnt_q != prev_lines_q;
            vga_d         = meas_is_vga;
            pal_d         = !meas_is_vga && (min_lines > PAL_TH);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LOCKED: begin
        if (vs_fall && (!consistent || len_dev)) begin
          state_d  = SEARCH;
          cnt_d    = '0;
          stable_d = 1'b0;
          resync_d = 1'b1;
        end
      end
      LOST: begin
        stable_d    = 1'b0;
        no_signal_d = ~hs_fall;
        if (hs_fall) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Loss of hsync overrides whatever the field logic decided this cycle.
    if (timeout && state_q != LOST) begin
      state_d     = LOST;
      cnt_d       = '0;
      stable_d    = 1'b0;
      no_signal_d = 1'b1;
      resync_d    = (state_q == LOCKED);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      no_signal_q   <= 1'b1;
      resync_q      <= 1'b0;
      line_length_q <= '0;
      field_lines_q <= '0;
      interlaced_q  <= 1'b0;
      vga_q         <= 1'b0;
      pal_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      no_signal_q   <= no_signal_d;
      resync_q      <= resync_d;
      line_length_q <= line_length_d;
      field_lines_q <= field_lines_d;
      interlaced_q  <= interlaced_d;
      vga_q         <= vga_d;
      pal_q         <= pal_d;
    end
  end

  TimingInfo ti;

  assign ti = '{line_length: line_length_q,
                field_lines: field_lines_q,
                interlaced:  interlaced_q,
                is_pal:      pal_q};

  assign stable      = stable_q;
  assign no_signal   = no_signal_q;
  assign resync      = resync_q;
  assign line_length = line_length_q;
  assign field_lines = field_lines_q;
  assign interlaced  = interlaced_q;
  assign vga_mode    = vga_q;
  assign is_pal      = pal_q;
  assign timing_info = ti;

endmodule
